// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared types and helpers for the instruction-memory read unit
//   state_t    : fetch FSM states (IDLE, WAIT, RESP)
//   LAT_CNT_W  : width of the miss-latency down-counter
//   word_index : byte PC -> word index (PC >> 2), never wrapped
package instr_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int LAT_CNT_W = 4;

    // Full-width index so out-of-range upper PC bits are still visible to the range check
    function automatic logic [61:0] word_index(input logic [63:0] pc);
        return 62'(pc >> 2);
    endfunction

endpackage

// File: rtl/instr_mem_reader_store.sv
// imem_store: DEPTH x DW instruction array, one sync write port, one async read port
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write word index
//   wdata : write word
//   raddr : read word index
//   rdata : read word (combinational; a same-edge write is seen only after the edge)
module imem_store #(
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_reader.sv
// instr_mem_reader: instruction fetch unit with req/valid handshake, programmable miss latency,
//                   one-entry last-fetch cache and misaligned/out-of-range detection
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low reset
//   req, pc     : fetch request and byte address, sampled only while busy=0
//   busy        : high from the accept edge until the valid cycle ends
//   valid       : 1-cycle response pulse qualifying instruction/error
//   instruction : fetched word, held until the next response
//   error       : response is for a misaligned or out-of-range pc
//   load_en/load_addr/load_data : store write port, usable in any state
module instr_mem_reader
    import instr_mem_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter int            DEPTH    = 256,
    parameter int            READ_LAT = 2,
    parameter logic [DW-1:0] NOP_WORD = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [AW-1:0]            pc,
    output logic                     busy,
    output logic                     valid,
    output logic [DW-1:0]            instruction,
    output logic                     error,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DW-1:0]            load_data
);

    localparam int IW = $clog2(DEPTH);

    state_t               state, state_nxt;
    logic [LAT_CNT_W-1:0] cnt;
    logic [AW-1:0]        pc_q, cache_pc, fill_pc;
    logic [IW-1:0]        idx_q, rd_idx;
    logic [DW-1:0]        cache_word, rd_word;
    logic [61:0]          idx_in;
    logic                 cache_valid, accept, bad_in, hit_in, miss_now, wait_done, fill;

    imem_store #(.DW(DW), .DEPTH(DEPTH)) u_store (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    // Classification of the incoming request is made from the live pc on the accept edge
    always_comb begin
        idx_in    = word_index(64'(pc));
        accept    = state == IDLE && req;
        bad_in    = pc[1:0] != 2'b00 || idx_in >= 62'(DEPTH);
        hit_in    = cache_valid && pc == cache_pc;
        miss_now  = accept && !bad_in && !hit_in && READ_LAT == 1;
        wait_done = state == WAIT && cnt == LAT_CNT_W'(1);
        fill      = miss_now || wait_done;
        rd_idx    = miss_now ? idx_in[IW-1:0] : idx_q;
        fill_pc   = miss_now ? pc : pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == RESP ? IDLE :
                    state == WAIT ? (cnt == LAT_CNT_W'(1) ? RESP : WAIT) :
                    accept        ? ((bad_in || hit_in || READ_LAT == 1) ? RESP : WAIT) :
                                    IDLE;
    end

    always_comb begin
        busy  = state != IDLE;
        valid = state == RESP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_WORD;
            error       <= 1'b0;
            cnt         <= '0;
            pc_q        <= '0;
            idx_q       <= '0;
            cache_pc    <= '0;
            cache_word  <= '0;
            cache_valid <= 1'b0;
        end else begin
            if (accept) begin
                pc_q  <= pc;
                idx_q <= idx_in[IW-1:0];
                cnt   <= LAT_CNT_W'(READ_LAT - 1);
                if (bad_in) begin
                    error       <= 1'b1;
                    instruction <= NOP_WORD;
                end else if (hit_in) begin
                    error       <= 1'b0;
                    instruction <= cache_word;
                end
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (fill) begin
                error       <= 1'b0;
                instruction <= rd_word;
                cache_pc    <= fill_pc;
                cache_word  <= rd_word;
            end
            // A same-edge load to the filled index wins, since the fill captured the old word
            cache_valid <= fill ? !(load_en && load_addr == rd_idx)
                                : cache_valid && !(load_en && load_addr == cache_pc[IW+1:2]);
        end
    end

endmodule
